hx8352_bus_writer: RTL and testbench

- Physical-layer stage between the hx8352 controller/sequencer and the HX8352 LCD pins.
- Accepts command/data words over a valid/ready handshake and generates 8080-style 16-bit parallel write cycles with parameterised setup, strobe and hold timing.
- Owns the panel hardware-reset pulse: it runs after system reset and on request.

---
 rtl/hx8352_pkg.sv | 36 +++
 rtl/hx8352_bus_writer_if.sv | 17 +
 rtl/hx8352_delay_counter.sv | 42 ++++
 rtl/hx8352_bus_writer.sv | 186 ++++++++++++++++++
 tb/tb_hx8352_bus_writer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hx8352_pkg.sv
// hx8352_pkg
//   Shared definitions for the HX8352 write path: bus-cycle type codes,
//   FSM state encoding, default 50 MHz timing constants and small helpers
//   used to size and classify the timing logic.
package hx8352_pkg;

   // Register-select codes presented on lcd_rs
   localparam logic LCD_CMD  = 1'b0;
   localparam logic LCD_DATA = 1'b1;

   typedef enum logic [2:0] {
      RST_LOW,
      RST_WAIT,
      IDLE,
      SETUP,
      WR_LOW,
      WR_HIGH
   } state_t;

   // Default timing at 50 MHz
   localparam int unsigned DEF_T_SETUP         = 1;
   localparam int unsigned DEF_T_WRL           = 2;
   localparam int unsigned DEF_T_WRH           = 2;
   localparam int unsigned DEF_RST_LOW_CYCLES  = 500;        // 10 us
   localparam int unsigned DEF_RST_WAIT_CYCLES = 6_000_000;  // 120 ms

   function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // States in which chip select is asserted and the bus word is held
   function automatic logic in_write(input state_t s);
      return (s == SETUP) || (s == WR_LOW) || (s == WR_HIGH);
   endfunction

endpackage

// File: rtl/hx8352_bus_writer_if.sv
// hx8352_bus_writer_if
//   Valid/ready word channel from the controller/sequencer into the bus writer.
//   Signals:
//     in_valid  source -> writer  word available
//     in_ready  writer -> source  word accepted this cycle
//     in_dc     source -> writer  0 = command, 1 = data
//     in_data   source -> writer  16-bit word
//   Modports: master (source side), slave (bus writer side).
interface hx8352_bus_writer_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_dc;
   logic [15:0] in_data;

   modport master (output in_valid, output in_dc, output in_data, input in_ready);
   modport slave  (input in_valid, input in_dc, input in_data, output in_ready);
endinterface

// File: rtl/hx8352_delay_counter.sv
// hx8352_delay_counter
//   Loadable down-counter shared by every timed state of the bus writer.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset (count <= RESET_VAL)
//     load        load strobe; load_val is taken on the next edge
//     load_val    value to load (state duration minus one)
//     done        count has reached zero
//     near_done   count is one (only with HX8352_BURST_EN defined)
//   Config macro: HX8352_BURST_EN adds the near_done output.
module hx8352_delay_counter #(
   parameter int unsigned   W         = 8,
   parameter logic [W-1:0]  RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
`ifdef HX8352_BURST_EN
   output logic         near_done,
`endif
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

`ifdef HX8352_BURST_EN
   assign near_done = (count == W'(1));
`endif

endmodule

// File: rtl/hx8352_bus_writer.sv
// hx8352_bus_writer
//   Physical-layer stage driving the HX8352 8080-style 16-bit write bus and
//   the panel hardware reset. Words arrive over a valid/ready channel; each is
//   written as CS-low, setup, WR-low, WR-high, CS-high with parameterised
//   cycle counts. The panel reset pulse runs after system reset and on
//   hw_reset_start (deferred until an in-flight write completes).
//   Ports:
//     clk             system clock
//     rst             asynchronous active-low reset
//     hw_reset_start  single-cycle request to re-run the panel reset
//     bus             word channel (slave side): in_valid/in_ready/in_dc/in_data
//     busy            high in every state except IDLE
//     lcd_cs_n        chip select, active-low
//     lcd_rs          register select (latched in_dc)
//     lcd_wr_n        write strobe, active-low (panel latches on rising edge)
//     lcd_rd_n        read strobe, held high
//     lcd_rst_n       panel hardware reset, active-low
//     lcd_data        parallel data bus
//   Config macro: HX8352_BURST_EN keeps CS low and accepts the next word in
//   the last WR_HIGH cycle.
module hx8352_bus_writer
   import hx8352_pkg::*;
#(
   parameter int unsigned T_SETUP         = DEF_T_SETUP,
   parameter int unsigned T_WRL           = DEF_T_WRL,
   parameter int unsigned T_WRH           = DEF_T_WRH,
   parameter int unsigned RST_LOW_CYCLES  = DEF_RST_LOW_CYCLES,
   parameter int unsigned RST_WAIT_CYCLES = DEF_RST_WAIT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hw_reset_start,
   hx8352_bus_writer_if.slave   bus,
   output logic                 busy,
   output logic                 lcd_cs_n,
   output logic                 lcd_rs,
   output logic                 lcd_wr_n,
   output logic                 lcd_rd_n,
   output logic                 lcd_rst_n,
   output logic [15:0]          lcd_data
);

   localparam int unsigned CW = $clog2(max_of(max_of(max_of(T_SETUP, T_WRL),
                                                     max_of(T_WRH, RST_LOW_CYCLES)),
                                              RST_WAIT_CYCLES)) + 1;
   typedef logic [CW-1:0] cnt_t;

   // Counter preload for a state: its duration minus one
   function automatic cnt_t dur(input state_t s);
      cnt_t d;
      d = '0;
      case (s)
         RST_LOW:  d = cnt_t'(RST_LOW_CYCLES - 1);
         RST_WAIT: d = cnt_t'(RST_WAIT_CYCLES - 1);
         SETUP:    d = cnt_t'(T_SETUP - 1);
         WR_LOW:   d = cnt_t'(T_WRL - 1);
         WR_HIGH:  d = cnt_t'(T_WRH - 1);
         default:  d = '0;
      endcase
      return d;
   endfunction

   state_t      state, next_state;
   logic        pending, pending_d;
   logic        reset_req;
   logic        accept;
   logic        cnt_load, cnt_done;
   cnt_t        cnt_val;
   logic        in_ready_q;

   logic        busy_d, cs_n_d, rs_d, wr_n_d, rst_n_d, in_ready_d;
   logic [15:0] data_d;

`ifdef HX8352_BURST_EN
   logic        cnt_near_done;
   logic        last_next;
`endif

   assign bus.in_ready = in_ready_q;
   assign lcd_rd_n     = 1'b1;

   // Every timed state reloads on entry. The reset value covers the RST_LOW
   // entry caused by rst itself, which has no transition edge to load on.
   assign cnt_load = (next_state != state);
   assign cnt_val  = dur(next_state);

   hx8352_delay_counter #(
      .W         (CW),
      .RESET_VAL (cnt_t'(RST_LOW_CYCLES - 1))
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .load_val  (cnt_val),
`ifdef HX8352_BURST_EN
      .near_done (cnt_near_done),
`endif
      .done      (cnt_done)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RST_LOW;
         pending <= 1'b0;
      end else begin
         state   <= next_state;
         pending <= pending_d;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      reset_req  = pending | (hw_reset_start & in_write(state));
      case (state)
         RST_LOW:  if (cnt_done) next_state = RST_WAIT;
         RST_WAIT: if (cnt_done) next_state = IDLE;
         IDLE: begin
            if (hw_reset_start) begin
               next_state = RST_LOW;
            end else if (bus.in_valid && in_ready_q) begin
               accept     = 1'b1;
               next_state = SETUP;
            end
         end
         SETUP:    if (cnt_done) next_state = WR_LOW;
         WR_LOW:   if (cnt_done) next_state = WR_HIGH;
         WR_HIGH: begin
            if (cnt_done) begin
               if (reset_req) begin
                  next_state = RST_LOW;
`ifdef HX8352_BURST_EN
               end else if (bus.in_valid && in_ready_q) begin
                  accept     = 1'b1;
                  next_state = SETUP;
`endif
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default:  next_state = RST_LOW;
      endcase
      pending_d = reset_req & (next_state != RST_LOW);
   end

   // Output logic: registered pins follow the state being entered
   always_comb begin
      cs_n_d     = ~in_write(next_state);
      wr_n_d     = (next_state != WR_LOW);
      rst_n_d    = (next_state != RST_LOW);
      busy_d     = (next_state != IDLE);
      in_ready_d = (next_state == IDLE);
      data_d     = accept ? bus.in_data : lcd_data;
      rs_d       = accept ? bus.in_dc   : lcd_rs;
`ifdef HX8352_BURST_EN
      // Ready during the final WR_HIGH cycle unless a panel reset is owed
      last_next  = (next_state == WR_HIGH) &&
                   (cnt_load ? (cnt_val == '0) : cnt_near_done);
      in_ready_d = in_ready_d | (last_next & ~pending_d);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b1;
         lcd_cs_n   <= 1'b1;
         lcd_rs     <= 1'b0;
         lcd_wr_n   <= 1'b1;
         lcd_rst_n  <= 1'b0;
         lcd_data   <= '0;
         in_ready_q <= 1'b0;
      end else begin
         busy       <= busy_d;
         lcd_cs_n   <= cs_n_d;
         lcd_rs     <= rs_d;
         lcd_wr_n   <= wr_n_d;
         lcd_rst_n  <= rst_n_d;
         lcd_data   <= data_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_hx8352_bus_writer.sv
// tb_hx8352_bus_writer
//   Directed bench for hx8352_bus_writer with RST_LOW_CYCLES=10 and
//   RST_WAIT_CYCLES=20. Outputs are sampled 1 time unit after each rising
//   edge; inputs are driven at the same point. Expectations follow the
//   HX8352_BURST_EN setting of the build.
module tb_hx8352_bus_writer;
   import hx8352_pkg::*;

   localparam int RLOW  = 10;
   localparam int RWAIT = 20;
`ifdef HX8352_BURST_EN
   localparam int SPACING = 5;
   localparam int GAPS    = 0;
   localparam logic LAST_WRH_READY = 1'b1;
`else
   localparam int SPACING = 6;
   localparam int GAPS    = 3;
   localparam logic LAST_WRH_READY = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        hw_reset_start;
   logic        busy;
   logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n;
   logic [15:0] lcd_data;

   int n_chk  = 0;
   int n_fail = 0;

   hx8352_bus_writer_if bus_if();

   hx8352_bus_writer #(
      .RST_LOW_CYCLES  (RLOW),
      .RST_WAIT_CYCLES (RWAIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .hw_reset_start (hw_reset_start),
      .bus            (bus_if),
      .busy           (busy),
      .lcd_cs_n       (lcd_cs_n),
      .lcd_rs         (lcd_rs),
      .lcd_wr_n       (lcd_wr_n),
      .lcd_rd_n       (lcd_rd_n),
      .lcd_rst_n      (lcd_rst_n),
      .lcd_data       (lcd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        dc;
      logic [15:0] data;
      logic        exp_cs_n;
      logic        exp_wr_n;
      logic        exp_rs;
      logic        exp_ready;
      logic        exp_busy;
      logic [15:0] exp_data;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] words[4] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Current sample must be the first cycle with lcd_rst_n low
   task automatic run_reset_seq(input string tag);
      int   n_low;
      int   n_high;
      logic bad;
      n_low  = 0;
      n_high = 0;
      bad    = 1'b0;
      for (int i = 0; i < 200 && lcd_rst_n === 1'b0; i++) begin
         if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || bus_if.in_ready !== 1'b0 || busy !== 1'b1)
            bad = 1'b1;
         n_low++;
         step();
      end
      for (int i = 0; i < 200 && lcd_rst_n === 1'b1 && busy === 1'b1; i++) begin
         if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || bus_if.in_ready !== 1'b0)
            bad = 1'b1;
         n_high++;
         step();
      end
      chk({tag, "_rst_low_cycles"}, 32'(n_low), 32'(RLOW));
      chk({tag, "_rst_wait_cycles"}, 32'(n_high), 32'(RWAIT));
      chk({tag, "_pins_quiet"}, 32'(bad), 32'd0);
      chk({tag, "_ready_after"}, 32'(bus_if.in_ready), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 50 && bus_if.in_ready !== 1'b1; i++) step();
      chk({tag, "_idle"}, 32'(bus_if.in_ready), 32'd1);
   endtask

   task automatic stream_test();
      int   hs_cyc[4];
      int   idx, wcount, gaps;
      logic hs, prev_wr_n;
      idx = 0; wcount = 0; gaps = 0; prev_wr_n = 1'b1;
      for (int k = 0; k < 4; k++) hs_cyc[k] = 0;
      bus_if.in_valid = 1'b1;
      bus_if.in_dc    = LCD_DATA;
      bus_if.in_data  = words[0];
      for (int c = 0; c < 100; c++) begin
         hs = bus_if.in_valid && bus_if.in_ready;
         step();
         if (hs) begin
            hs_cyc[idx] = c;
            idx++;
            if (idx < 4) bus_if.in_data = words[idx];
            else         bus_if.in_valid = 1'b0;
         end
         if (lcd_wr_n === 1'b0 && prev_wr_n === 1'b1 && wcount < 4) begin
            chk($sformatf("stream_data[%0d]", wcount), 32'(lcd_data), 32'(words[wcount]));
            chk($sformatf("stream_rs[%0d]", wcount), 32'(lcd_rs), 32'(LCD_DATA));
            wcount++;
         end
         if (lcd_cs_n === 1'b1 && wcount >= 1 && wcount <= 3) gaps++;
         prev_wr_n = lcd_wr_n;
         if (idx == 4 && wcount == 4 && bus_if.in_ready === 1'b1 && busy === 1'b0) break;
      end
      chk("stream_words_written", 32'(wcount), 32'd4);
      for (int k = 0; k < 3; k++)
         chk($sformatf("stream_spacing[%0d]", k), 32'(hs_cyc[k+1] - hs_cyc[k]), 32'(SPACING));
      chk("stream_cs_gaps", 32'(gaps), 32'(GAPS));
   endtask

   task automatic hw_reset_mid_write();
      int   n_wrl, n_wrh;
      logic saw_idle, saw_ready, found;
      n_wrl = 0; n_wrh = 0; saw_idle = 1'b0; saw_ready = 1'b0; found = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_dc    = LCD_DATA;
      bus_if.in_data  = 16'h1234;
      step();                       // SETUP
      bus_if.in_valid = 1'b0;
      step();                       // first WR_LOW cycle
      chk("hwr_in_wr_low", 32'(lcd_wr_n), 32'd0);
      if (lcd_wr_n === 1'b0) n_wrl++;
      hw_reset_start = 1'b1;
      step();
      hw_reset_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (lcd_rst_n === 1'b0) begin
            found = 1'b1;
            break;
         end
         if (lcd_wr_n === 1'b0) n_wrl++;
         else if (lcd_cs_n === 1'b0) n_wrh++;
         if (busy === 1'b0) saw_idle = 1'b1;
         if (bus_if.in_ready === 1'b1) saw_ready = 1'b1;
         step();
      end
      chk("hwr_reset_started", 32'(found), 32'd1);
      chk("hwr_wr_low_cycles", 32'(n_wrl), 32'd2);
      chk("hwr_wr_high_cycles", 32'(n_wrh), 32'd2);
      chk("hwr_no_idle", 32'(saw_idle), 32'd0);
      chk("hwr_no_ready", 32'(saw_ready), 32'd0);
      chk("hwr_cs_released", 32'(lcd_cs_n), 32'd1);
      chk("hwr_data_kept", 32'(lcd_data), 32'h1234);
      run_reset_seq("hwr");
   endtask

   task automatic hw_reset_with_valid();
      bus_if.in_valid = 1'b1;
      bus_if.in_dc    = LCD_CMD;
      bus_if.in_data  = 16'h002C;
      hw_reset_start  = 1'b1;
      step();
      hw_reset_start  = 1'b0;
      chk("hwv_cs_n", 32'(lcd_cs_n), 32'd1);
      chk("hwv_rst_n", 32'(lcd_rst_n), 32'd0);
      chk("hwv_ready", 32'(bus_if.in_ready), 32'd0);
      run_reset_seq("hwv");
      step();                       // word held valid is accepted now
      bus_if.in_valid = 1'b0;
      chk("hwv_accept_cs_n", 32'(lcd_cs_n), 32'd0);
      chk("hwv_accept_data", 32'(lcd_data), 32'h002C);
      chk("hwv_accept_rs", 32'(lcd_rs), 32'(LCD_CMD));
      wait_idle("hwv");
   endtask

   task automatic async_reset_mid_write();
      bus_if.in_valid = 1'b1;
      bus_if.in_dc    = LCD_DATA;
      bus_if.in_data  = 16'hBEEF;
      step();
      bus_if.in_valid = 1'b0;
      step();
      chk("arst_in_wr_low", 32'(lcd_wr_n), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("arst_wr_n", 32'(lcd_wr_n), 32'd1);
      chk("arst_cs_n", 32'(lcd_cs_n), 32'd1);
      chk("arst_rst_n", 32'(lcd_rst_n), 32'd0);
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_ready", 32'(bus_if.in_ready), 32'd0);
      chk("arst_data", 32'(lcd_data), 32'd0);
      step();
      rst = 1'b1;
      run_reset_seq("arst");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      // Single command word: 0022, then idle inputs carrying junk data
      vecs[0] = '{1'b1, LCD_CMD,  16'h0022, 1'b0, 1'b1, LCD_CMD, 1'b0, 1'b1, 16'h0022}; // SETUP
      vecs[1] = '{1'b0, LCD_DATA, 16'hDEAD, 1'b0, 1'b0, LCD_CMD, 1'b0, 1'b1, 16'h0022}; // WR_LOW
      vecs[2] = '{1'b0, LCD_DATA, 16'hDEAD, 1'b0, 1'b0, LCD_CMD, 1'b0, 1'b1, 16'h0022}; // WR_LOW
      vecs[3] = '{1'b0, LCD_DATA, 16'hDEAD, 1'b0, 1'b1, LCD_CMD, 1'b0, 1'b1, 16'h0022}; // WR_HIGH
      vecs[4] = '{1'b0, LCD_DATA, 16'hDEAD, 1'b0, 1'b1, LCD_CMD, LAST_WRH_READY, 1'b1, 16'h0022};
      vecs[5] = '{1'b0, LCD_DATA, 16'hDEAD, 1'b1, 1'b1, LCD_CMD, 1'b1, 1'b0, 16'h0022}; // IDLE

      rst             = 1'b0;
      hw_reset_start  = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_dc    = 1'b0;
      bus_if.in_data  = '0;
      step();
      step();
      chk("rst_lcd_rst_n", 32'(lcd_rst_n), 32'd0);
      chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
      chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
      chk("rst_rd_n", 32'(lcd_rd_n), 32'd1);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'd0);
      chk("rst_ready", 32'(bus_if.in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      rst = 1'b1;
      run_reset_seq("pwr");

      for (int i = 0; i < 6; i++) begin
         bus_if.in_valid = vecs[i].valid;
         bus_if.in_dc    = vecs[i].dc;
         bus_if.in_data  = vecs[i].data;
         step();
         chk($sformatf("cmd[%0d].cs_n", i), 32'(lcd_cs_n), 32'(vecs[i].exp_cs_n));
         chk($sformatf("cmd[%0d].wr_n", i), 32'(lcd_wr_n), 32'(vecs[i].exp_wr_n));
         chk($sformatf("cmd[%0d].rs", i), 32'(lcd_rs), 32'(vecs[i].exp_rs));
         chk($sformatf("cmd[%0d].ready", i), 32'(bus_if.in_ready), 32'(vecs[i].exp_ready));
         chk($sformatf("cmd[%0d].busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("cmd[%0d].data", i), 32'(lcd_data), 32'(vecs[i].exp_data));
         chk($sformatf("cmd[%0d].rd_n", i), 32'(lcd_rd_n), 32'd1);
         chk($sformatf("cmd[%0d].rst_n", i), 32'(lcd_rst_n), 32'd1);
      end

      stream_test();
      wait_idle("stream");
      hw_reset_mid_write();
      hw_reset_with_valid();
      async_reset_mid_write();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
